// File: rtl/floating_add_compare_divide_pkg.sv
// Shared constants, divider state encoding and small binary32 helpers
// used by the add/compare datapath and the iterative divider.
package floating_add_compare_divide_pkg;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b11;
    localparam logic [1:0] CMP_UN = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_PACK = 2'd2
    } div_state_t;

    // NaN: all-ones exponent with a nonzero fraction
    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Infinity: all-ones exponent with a zero fraction
    function automatic logic fp_is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    // Zero exponent covers true zeros and denormals, both handled as signed zero
    function automatic logic fp_is_zero(input logic [31:0] x);
        return (x[30:23] == 8'd0);
    endfunction

    // Number of leading zeros of a 27-bit aligned magnitude
    function automatic logic [4:0] lead_zeros(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (found) begin
                n = n;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                n = n + 5'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/floating_add_compare_divide_div.sv
// Iterative restoring divider for binary32: one quotient bit per cycle,
// 25 iterations followed by a pack cycle, truncating result.
module fp_divide_iter
    import floating_add_compare_divide_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  iter_count
);

    div_state_t  state_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [24:0] rem_r;
    logic [24:0] quo_r;

    logic [24:0]       mb_s;
    logic              rem_ge_s;
    logic [24:0]       trial_s;
    logic              sign_s;
    logic signed [9:0] exp_s;
    logic [22:0]       frac_s;
    logic [31:0]       pack_s;

    // One restoring step plus the final normalise/special-case packing
    always_comb begin
        mb_s     = {2'b01, b_r[22:0]};
        rem_ge_s = (rem_r >= mb_s);
        if (rem_ge_s) begin
            trial_s = rem_r - mb_s;
        end else begin
            trial_s = rem_r;
        end

        sign_s = a_r[31] ^ b_r[31];
        if (quo_r[24]) begin
            exp_s  = $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]}) + 10'sd127;
            frac_s = 23'(quo_r >> 1);
        end else begin
            exp_s  = $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]}) + 10'sd126;
            frac_s = 23'(quo_r);
        end

        if (fp_is_nan(a_r) || fp_is_nan(b_r)) begin
            pack_s = QNAN;
        end else if (fp_is_zero(a_r) && fp_is_zero(b_r)) begin
            pack_s = QNAN;
        end else if (fp_is_inf(a_r) && fp_is_inf(b_r)) begin
            pack_s = QNAN;
        end else if (fp_is_inf(a_r) || fp_is_zero(b_r)) begin
            pack_s = {sign_s, POS_INF[30:0]};
        end else if (fp_is_zero(a_r) || fp_is_inf(b_r)) begin
            pack_s = {sign_s, 31'd0};
        end else if (exp_s >= 10'sd255) begin
            pack_s = {sign_s, POS_INF[30:0]};
        end else if (exp_s <= 10'sd0) begin
            pack_s = 32'd0;
        end else begin
            pack_s = {sign_s, exp_s[7:0], frac_s};
        end
    end

    // Divider FSM: IDLE latches operands, ITER shifts out quotient bits, PACK publishes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= DIV_IDLE;
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            rem_r      <= 25'd0;
            quo_r      <= 25'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 32'd0;
            iter_count <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                DIV_IDLE: begin
                    if (start) begin
                        a_r        <= a;
                        b_r        <= b;
                        rem_r      <= {2'b01, a[22:0]};
                        quo_r      <= 25'd0;
                        iter_count <= 5'd0;
                        busy       <= 1'b1;
                        state_r    <= DIV_ITER;
                    end else begin
                        state_r <= DIV_IDLE;
                    end
                end
                DIV_ITER: begin
                    quo_r      <= {quo_r[23:0], rem_ge_s};
                    rem_r      <= trial_s << 1;
                    iter_count <= iter_count + 5'd1;
                    if (iter_count == 5'd24) begin
                        state_r <= DIV_PACK;
                    end else begin
                        state_r <= DIV_ITER;
                    end
                end
                DIV_PACK: begin
                    result     <= pack_s;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    iter_count <= 5'd0;
                    state_r    <= DIV_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/floating_add_compare_divide.sv
// binary32 add/sub and compare units (single-cycle, registered) alongside
// an independent iterative divider.
module floating_add_compare_divide
    import floating_add_compare_divide_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    input  logic        add_en,
    input  logic        cmp_en,
    input  logic        div_en,
    output logic [31:0] add_result,
    output logic [1:0]  cmp_result,
    output logic [31:0] div_result,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] debug
);

    logic              sa_s, sb_s;
    logic [7:0]        ea_s, eb_s;
    logic              nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;
    logic [26:0]       ma_s, mb_s, big_m_s, small_m_s, aligned_s, lost_mask_s;
    logic [26:0]       diff_m_s, norm_m_s;
    logic [27:0]       sum_m_s;
    logic [7:0]        big_e_s, small_e_s, exp_diff_s;
    logic              big_sign_s, a_bigger_s, mag_zero_s;
    logic [4:0]        lz_s;
    logic signed [9:0] exp_s;
    logic [22:0]       frac_s;
    logic [31:0]       add_next_s;

    logic signed [32:0] key_a_s, key_b_s;
    logic [1:0]         cmp_next_s;

    logic [4:0] iter_count;

    // Add/sub datapath: align with guard+round+sticky, add/sub, normalise, truncate
    always_comb begin
        sa_s     = a[31];
        sb_s     = b[31] ^ sub;
        ea_s     = a[30:23];
        eb_s     = b[30:23];
        nan_a_s  = fp_is_nan(a);
        nan_b_s  = fp_is_nan(b);
        inf_a_s  = fp_is_inf(a);
        inf_b_s  = fp_is_inf(b);
        zero_a_s = fp_is_zero(a);
        zero_b_s = fp_is_zero(b);
        ma_s     = zero_a_s ? 27'd0 : {1'b1, a[22:0], 3'b000};
        mb_s     = zero_b_s ? 27'd0 : {1'b1, b[22:0], 3'b000};

        a_bigger_s = ({ea_s, a[22:0]} >= {eb_s, b[22:0]});
        if (a_bigger_s) begin
            big_m_s    = ma_s;
            big_e_s    = ea_s;
            big_sign_s = sa_s;
            small_m_s  = mb_s;
            small_e_s  = eb_s;
        end else begin
            big_m_s    = mb_s;
            big_e_s    = eb_s;
            big_sign_s = sb_s;
            small_m_s  = ma_s;
            small_e_s  = ea_s;
        end

        // Bits shifted out of the smaller operand collapse into a sticky LSB
        exp_diff_s = big_e_s - small_e_s;
        if (exp_diff_s >= 8'd27) begin
            lost_mask_s = {27{1'b1}};
            aligned_s   = 27'd0;
        end else begin
            lost_mask_s = ~({27{1'b1}} << exp_diff_s);
            aligned_s   = small_m_s >> exp_diff_s;
        end
        aligned_s[0] = aligned_s[0] | (|(small_m_s & lost_mask_s));

        sum_m_s  = {1'b0, big_m_s} + {1'b0, aligned_s};
        diff_m_s = big_m_s - aligned_s;
        lz_s     = lead_zeros(diff_m_s);
        norm_m_s = diff_m_s << lz_s;

        if (sa_s == sb_s) begin
            mag_zero_s = 1'b0;
            if (sum_m_s[27]) begin
                frac_s = 23'(sum_m_s >> 4);
                exp_s  = $signed({2'b00, big_e_s}) + 10'sd1;
            end else begin
                frac_s = 23'(sum_m_s >> 3);
                exp_s  = $signed({2'b00, big_e_s});
            end
        end else begin
            mag_zero_s = (diff_m_s == 27'd0);
            frac_s     = 23'(norm_m_s >> 3);
            exp_s      = $signed({2'b00, big_e_s}) - $signed({5'b00000, lz_s});
        end

        if (nan_a_s || nan_b_s) begin
            add_next_s = QNAN;
        end else if (inf_a_s && inf_b_s && (sa_s != sb_s)) begin
            add_next_s = QNAN;
        end else if (inf_a_s) begin
            add_next_s = {sa_s, POS_INF[30:0]};
        end else if (inf_b_s) begin
            add_next_s = {sb_s, POS_INF[30:0]};
        end else if (zero_a_s && zero_b_s) begin
            add_next_s = (!sub && a[31] && b[31]) ? 32'h8000_0000 : 32'd0;
        end else if (zero_a_s) begin
            add_next_s = {sb_s, b[30:0]};
        end else if (zero_b_s) begin
            add_next_s = a;
        end else if (mag_zero_s) begin
            add_next_s = 32'd0;
        end else if (exp_s >= 10'sd255) begin
            add_next_s = {big_sign_s, POS_INF[30:0]};
        end else if (exp_s <= 10'sd0) begin
            add_next_s = 32'd0;
        end else begin
            add_next_s = {big_sign_s, exp_s[7:0], frac_s};
        end
    end

    // Compare: map each operand onto a signed ordering key, zeros and denormals collapse to 0
    always_comb begin
        if (zero_a_s) begin
            key_a_s = 33'sd0;
        end else if (a[31]) begin
            key_a_s = -$signed({2'b00, a[30:0]});
        end else begin
            key_a_s = $signed({2'b00, a[30:0]});
        end
        if (zero_b_s) begin
            key_b_s = 33'sd0;
        end else if (b[31]) begin
            key_b_s = -$signed({2'b00, b[30:0]});
        end else begin
            key_b_s = $signed({2'b00, b[30:0]});
        end

        if (nan_a_s || nan_b_s) begin
            cmp_next_s = CMP_UN;
        end else if (key_a_s == key_b_s) begin
            cmp_next_s = CMP_EQ;
        end else if (key_a_s > key_b_s) begin
            cmp_next_s = CMP_GT;
        end else begin
            cmp_next_s = CMP_LT;
        end
    end

    // Result registers for the add and compare units; each holds when not enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add_result <= 32'd0;
            cmp_result <= CMP_EQ;
        end else begin
            if (add_en) begin
                add_result <= add_next_s;
            end else begin
                add_result <= add_result;
            end
            if (cmp_en) begin
                cmp_result <= cmp_next_s;
            end else begin
                cmp_result <= cmp_result;
            end
        end
    end

    fp_divide_iter u_div (
        .clk        (clk),
        .reset      (reset),
        .start      (div_en),
        .a          (a),
        .b          (b),
        .busy       (div_busy),
        .done       (div_done),
        .result     (div_result),
        .iter_count (iter_count)
    );

    assign debug = {23'd0, div_busy, 3'd0, iter_count};

endmodule

// File: tb/tb_floating_add_compare_divide.sv
// Self-checking bench: directed vectors plus randomized operands compared
// against an arithmetic reference model of binary32 add/compare/divide.
module tb_floating_add_compare_divide;

    logic        clk;
    logic        reset;
    logic [31:0] a, b;
    logic        sub, add_en, cmp_en, div_en;
    logic [31:0] add_result, div_result, debug;
    logic [1:0]  cmp_result;
    logic        div_busy, div_done;

    int n_checks = 0;
    int n_pass   = 0;

    floating_add_compare_divide dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .sub        (sub),
        .add_en     (add_en),
        .cmp_en     (cmp_en),
        .div_en     (div_en),
        .add_result (add_result),
        .cmp_result (cmp_result),
        .div_result (div_result),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .debug      (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Exact sum on a wide integer grid (unit 2^-149), then truncate to binary32
    function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y, input logic s_op);
        logic sx, sy, s;
        int ex, ey, p, e;
        logic [287:0] vx, vy, mag, sh;
        sx = x[31]; sy = y[31] ^ s_op;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        if ((ex == 255 && x[22:0] != 23'd0) || (ey == 255 && y[22:0] != 23'd0)) return 32'h7FC00000;
        if (ex == 255 && ey == 255) return (sx != sy) ? 32'h7FC00000 : {sx, 31'h7F800000};
        if (ex == 255) return {sx, 31'h7F800000};
        if (ey == 255) return {sy, 31'h7F800000};
        if (ex == 0 && ey == 0) return (!s_op && sx && sy) ? 32'h80000000 : 32'h00000000;
        vx = (ex == 0) ? 288'd0 : (288'({1'b1, x[22:0]}) << (ex - 1));
        vy = (ey == 0) ? 288'd0 : (288'({1'b1, y[22:0]}) << (ey - 1));
        if (sx == sy) begin mag = vx + vy; s = sx; end
        else if (vx >= vy) begin mag = vx - vy; s = sx; end
        else begin mag = vy - vx; s = sy; end
        if (mag == 288'd0) return 32'h00000000;
        p = 0;
        for (int i = 0; i < 288; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e >= 255) return {s, 31'h7F800000};
        if (e <= 0) return 32'h00000000;
        sh = mag >> (p - 23);
        return {s, 8'(e), sh[22:0]};
    endfunction

    function automatic real to_real(input logic [31:0] x);
        real v;
        if (x[30:23] == 8'd0) return 0.0;
        if (x[30:23] == 8'hFF) return x[31] ? -1.0e300 : 1.0e300;
        v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (real'(int'(x[30:23])) - 127.0));
        return x[31] ? -v : v;
    endfunction

    function automatic logic [1:0] m_cmp(input logic [31:0] x, input logic [31:0] y);
        real rx, ry;
        if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0)) return 2'b10;
        rx = to_real(x); ry = to_real(y);
        if (rx == ry) return 2'b00;
        if (rx > ry) return 2'b01;
        return 2'b11;
    endfunction

    // Quotient of significands by integer division, truncated to 24 bits
    function automatic logic [31:0] m_div(input logic [31:0] x, input logic [31:0] y);
        logic s;
        int ex, ey, e;
        logic nx, ny, ix, iy, zx, zy;
        logic [63:0] q;
        s = x[31] ^ y[31];
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        nx = (ex == 255) && (x[22:0] != 23'd0); ny = (ey == 255) && (y[22:0] != 23'd0);
        ix = (ex == 255) && !nx; iy = (ey == 255) && !ny;
        zx = (ex == 0); zy = (ey == 0);
        if (nx || ny || (zx && zy) || (ix && iy)) return 32'h7FC00000;
        if (ix || zy) return {s, 31'h7F800000};
        if (zx || iy) return {s, 31'd0};
        q = (64'({1'b1, x[22:0]}) << 24) / 64'({1'b1, y[22:0]});
        e = ex - ey + 126;
        if (q >= 64'd16777216) begin q = q >> 1; e = e + 1; end
        if (e >= 255) return {s, 31'h7F800000};
        if (e <= 0) return 32'h00000000;
        return {s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0:       r[30:23] = 8'd0;
            1:       r[30:0]  = 31'h7F800000;
            2:       begin r[30:23] = 8'hFF; r[22] = 1'b1; end
            3:       r[30:23] = 8'(254 - $urandom_range(0, 1));
            4:       r[30:23] = 8'($urandom_range(1, 3));
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    task automatic run_div(input string tag, input logic [31:0] da, input logic [31:0] db, input bit reissue);
        int cnt;
        logic [31:0] exp_q;
        exp_q = m_div(da, db);
        a = da; b = db; div_en = 1'b1;
        step();
        div_en = 1'b0;
        check({tag, "_busy"}, 32'(div_busy), 32'd1);
        cnt = 0;
        while (cnt < 40 && div_done !== 1'b1) begin
            if (reissue && cnt == 5) begin
                a = 32'h3F800000; b = 32'h40800000; div_en = 1'b1;
            end else begin
                div_en = 1'b0;
            end
            step();
            cnt++;
        end
        div_en = 1'b0;
        check({tag, "_latency"}, 32'(cnt), 32'd26);
        check({tag, "_quotient"}, div_result, exp_q);
        check({tag, "_busy_drop"}, 32'(div_busy), 32'd0);
        step();
        check({tag, "_pulse_end"}, 32'(div_done), 32'd0);
    endtask

    initial begin
        logic [31:0] last_add;
        logic [1:0]  last_cmp;
        int          done_seen;

        reset = 1'b1; a = 32'd0; b = 32'd0; sub = 1'b0;
        add_en = 1'b0; cmp_en = 1'b0; div_en = 1'b0;
        #12;
        check("reset_add", add_result, 32'd0);
        check("reset_cmp", 32'(cmp_result), 32'd0);
        check("reset_div", div_result, 32'd0);
        check("reset_debug", debug, 32'd0);
        reset = 1'b0;

        // Directed add/sub
        a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; add_en = 1'b1;
        step(); check("add_1p2", add_result, 32'h40400000);
        a = 32'h3F800000; b = 32'h3F800000; sub = 1'b1;
        step(); check("sub_self", add_result, 32'h00000000);
        a = 32'h7F7FFFFF; b = 32'h7F7FFFFF; sub = 1'b0;
        step(); check("add_ovf", add_result, 32'h7F800000);
        a = 32'h80000000; b = 32'h80000000; sub = 1'b0;
        step(); check("add_negzero", add_result, 32'h80000000);
        a = 32'h7F800000; b = 32'h7F800000; sub = 1'b1;
        step(); check("inf_minus_inf", add_result, 32'h7FC00000);
        add_en = 1'b0;

        // Directed compare
        cmp_en = 1'b1;
        a = 32'h40000000; b = 32'h3F800000; step(); check("cmp_gt", 32'(cmp_result), 32'd1);
        a = 32'h3F800000; b = 32'h40000000; step(); check("cmp_lt", 32'(cmp_result), 32'd3);
        a = 32'h80000000; b = 32'h00000000; step(); check("cmp_zeros", 32'(cmp_result), 32'd0);
        a = 32'h7FC00000; b = 32'h3F800000; step(); check("cmp_nan", 32'(cmp_result), 32'd2);
        cmp_en = 1'b0;

        // Directed divides, including ignored re-request while busy
        run_div("div_6by2", 32'h40C00000, 32'h40000000, 1'b0);
        run_div("div_by_zero", 32'h3F800000, 32'h00000000, 1'b0);
        run_div("div_reissue", 32'h40C00000, 32'h40000000, 1'b1);
        run_div("div_zero_zero", 32'h00000000, 32'h80000000, 1'b0);

        // All three units enabled on the same edge
        a = 32'h40000000; b = 32'h3F800000; sub = 1'b0;
        add_en = 1'b1; cmp_en = 1'b1; div_en = 1'b1;
        step();
        add_en = 1'b0; cmp_en = 1'b0; div_en = 1'b0;
        check("simul_add", add_result, 32'h40400000);
        check("simul_cmp", 32'(cmp_result), 32'd1);
        check("simul_busy", 32'(div_busy), 32'd1);
        for (int i = 0; i < 25; i++) step();
        step();
        check("simul_done", 32'(div_done), 32'd1);
        check("simul_div", div_result, 32'h40000000);

        // Randomized add/sub and compare against the model
        add_en = 1'b1; cmp_en = 1'b1;
        last_add = 32'd0; last_cmp = 2'b00;
        for (int i = 0; i < 60; i++) begin
            a = rnd_fp();
            b = rnd_fp();
            if (i % 4 == 0) begin
                b = a ^ 32'($urandom_range(0, 255));
                b[31] = 1'($urandom);
            end
            sub = 1'($urandom);
            last_add = m_add(a, b, sub);
            last_cmp = m_cmp(a, b);
            step();
            check($sformatf("rand_add_%0d a=%h b=%h sub=%0d", i, a, b, sub), add_result, last_add);
            check($sformatf("rand_cmp_%0d a=%h b=%h", i, a, b), 32'(cmp_result), 32'(last_cmp));
        end

        // Disabled units hold their previous values
        add_en = 1'b0; cmp_en = 1'b0;
        a = 32'h3F800000; b = 32'h7FC00000;
        step();
        check("add_hold", add_result, last_add);
        check("cmp_hold", 32'(cmp_result), 32'(last_cmp));

        // Randomized divides
        for (int i = 0; i < 8; i++) begin
            run_div($sformatf("rand_div_%0d", i), rnd_fp(), rnd_fp(), 1'b0);
        end

        // Reset in the middle of a divide aborts it
        a = 32'h40C00000; b = 32'h40000000; div_en = 1'b1; add_en = 1'b1; cmp_en = 1'b1;
        step();
        div_en = 1'b0; add_en = 1'b0; cmp_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid_div_debug", debug, {23'd0, 1'b1, 3'd0, 5'd10});
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(div_busy), 32'd0);
        check("abort_div_result", div_result, 32'd0);
        check("abort_add_result", add_result, 32'd0);
        check("abort_cmp_result", 32'(cmp_result), 32'd0);
        check("abort_debug", debug, 32'd0);
        #2;
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (div_done === 1'b1) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_idle", 32'(div_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
